// File: rtl/key_debounce4_if.sv
// Four-key debouncer signal bundle: raw key lines in, debounced levels plus
// change/any flags out.
interface key_debounce4_if;
    logic key0;
    logic key1;
    logic key2;
    logic key3;
    logic y0;
    logic y1;
    logic y2;
    logic y3;
    logic chg;
    logic any;

    modport slave (
        input  key0, key1, key2, key3,
        output y0, y1, y2, y3, chg, any
    );

    modport master (
        output key0, key1, key2, key3,
        input  y0, y1, y2, y3, chg, any
    );
endinterface

// File: rtl/key_debounce4.sv
// Four independent key debouncers: two-flop synchronizer, saturating agreement
// counter per channel, registered levels plus a one-cycle change pulse.
module key_debounce4 #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    key_debounce4_if.slave  kd
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       key_s;
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       y_q;
    logic [3:0]       y_d;
    logic             chg_q;
    logic             chg_d;
    logic             any_q;
    logic             any_d;

    assign key_s = {kd.key3, kd.key2, kd.key1, kd.key0};

    // Two-flop synchronizer on the raw asynchronous key lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 4'b0000;
            sync2_q <= 4'b0000;
        end else begin
            sync1_q <= key_s;
            sync2_q <= sync1_q;
        end
    end

    // Per-channel debounce decision; >= keeps an out-of-range count from wrapping.
    always_comb begin
        y_d = y_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] == y_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] >= CNT_MAX) begin
                y_d[i]   = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        chg_d = |(y_d ^ y_q);
        any_d = |y_d;
    end

    // Counter, level and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            y_q   <= 4'b0000;
            chg_q <= 1'b0;
            any_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            y_q   <= y_d;
            chg_q <= chg_d;
            any_q <= any_d;
        end
    end

    assign kd.y0  = y_q[0];
    assign kd.y1  = y_q[1];
    assign kd.y2  = y_q[2];
    assign kd.y3  = y_q[3];
    assign kd.chg = chg_q;
    assign kd.any = any_q;

endmodule

// File: tb/tb_key_debounce4.sv
// Directed-vector bench for key_debounce4 at DB_CYCLES=4: one row per clock,
// keys driven on the falling edge, outputs compared just after the rising edge.
module tb_key_debounce4;

    typedef struct {
        logic [3:0] key;
        logic [3:0] y;
        logic       chg;
        logic       any;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    key_debounce4_if kd_if();

    key_debounce4 #(.DB_CYCLES(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kd    (kd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input int n, input logic [3:0] k, input logic [3:0] ey,
                       input logic ec, input logic ea);
        vec_t v;
        v.key = k;
        v.y   = ey;
        v.chg = ec;
        v.any = ea;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic drive_keys(input logic [3:0] k);
        kd_if.key0 = k[0];
        kd_if.key1 = k[1];
        kd_if.key2 = k[2];
        kd_if.key3 = k[3];
    endtask

    task automatic check(input string nm, input logic [3:0] ey, input logic ec,
                         input logic ea);
        logic [3:0] ay;
        ay = {kd_if.y3, kd_if.y2, kd_if.y1, kd_if.y0};
        checks++;
        if ({ay, kd_if.chg, kd_if.any} !== {ey, ec, ea}) begin
            errors++;
            $display("FAIL %s: got y=%b chg=%b any=%b, expected y=%b chg=%b any=%b",
                     nm, ay, kd_if.chg, kd_if.any, ey, ec, ea);
        end
    endtask

    task automatic step(input logic [3:0] k, input logic [3:0] ey, input logic ec,
                        input logic ea, input string nm);
        @(negedge clk);
        drive_keys(k);
        @(posedge clk);
        #1;
        check(nm, ey, ec, ea);
    endtask

    // Seven edges after reset release with keys k held; accept on the sixth.
    task automatic after_release(input logic [3:0] k, input string nm);
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", nm, c), (c >= 5) ? k : 4'b0000,
                  (c == 5) ? 1'b1 : 1'b0, (c >= 5) ? 1'b1 : 1'b0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive_keys(4'b0000);

        // key2 press then release: accept on the 6th edge after first sample
        add(5, 4'b0100, 4'b0000, 1'b0, 1'b0);
        add(1, 4'b0100, 4'b0100, 1'b1, 1'b1);
        add(1, 4'b0100, 4'b0100, 1'b0, 1'b1);
        add(5, 4'b0000, 4'b0100, 1'b0, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // key1 3-cycle glitch never reaches y1
        add(3, 4'b0010, 4'b0000, 1'b0, 1'b0);
        add(6, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // key1 4-cycle pulse is just long enough, then its release is debounced
        add(4, 4'b0010, 4'b0000, 1'b0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        add(1, 4'b0000, 4'b0010, 1'b1, 1'b1);
        add(3, 4'b0000, 4'b0010, 1'b0, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 1'b0);
        add(2, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // key3 bounce 1,0,1,0 then stable
        add(1, 4'b1000, 4'b0000, 1'b0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        add(1, 4'b1000, 4'b0000, 1'b0, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        add(5, 4'b1000, 4'b0000, 1'b0, 1'b0);
        add(1, 4'b1000, 4'b1000, 1'b1, 1'b1);
        add(1, 4'b1000, 4'b1000, 1'b0, 1'b1);
        // key3 release
        add(5, 4'b0000, 4'b1000, 1'b0, 1'b1);
        add(1, 4'b0000, 4'b0000, 1'b1, 1'b0);
        add(1, 4'b0000, 4'b0000, 1'b0, 1'b0);
        // key0 and key3 together, then key3 alone released with y0 held
        add(5, 4'b1001, 4'b0000, 1'b0, 1'b0);
        add(1, 4'b1001, 4'b1001, 1'b1, 1'b1);
        add(1, 4'b1001, 4'b1001, 1'b0, 1'b1);
        add(5, 4'b0001, 4'b1001, 1'b0, 1'b1);
        add(1, 4'b0001, 4'b0001, 1'b1, 1'b1);
        add(1, 4'b0001, 4'b0001, 1'b0, 1'b1);
        // key1 then key2 one cycle apart: chg high on two consecutive cycles
        add(1, 4'b0011, 4'b0001, 1'b0, 1'b1);
        add(4, 4'b0111, 4'b0001, 1'b0, 1'b1);
        add(1, 4'b0111, 4'b0011, 1'b1, 1'b1);
        add(1, 4'b0111, 4'b0111, 1'b1, 1'b1);
        add(1, 4'b0111, 4'b0111, 1'b0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].key, vecs[i].y, vecs[i].chg, vecs[i].any,
                 $sformatf("vec[%0d]", i));
        end

        // Partial debounce interrupted by reset; outputs clear without a clock edge
        for (int i = 0; i < 4; i++) begin
            step(4'b0010, 4'b0111, 1'b0, 1'b1, $sformatf("mid_cnt[%0d]", i));
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset", 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_hold", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        after_release(4'b0010, "key1_post_reset");

        // All keys held through reset release
        @(negedge clk);
        rst_n = 1'b0;
        drive_keys(4'b1111);
        #1;
        check("async_reset2", 4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        after_release(4'b1111, "all_keys");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce4.md
KEY_DEBOUNCE4 -- requirements
Module: key_debounce4

Interface
REQ-001 Parameter DB_CYCLES, default 4, meaning consecutive synchronized cycles of disagreement needed to accept a new level (legal range 2..255).
REQ-002 Parameter CNT_W, default 8, meaning debounce counter width; SHALL satisfy 2**CNT_W > DB_CYCLES-1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; deasserted synchronously to clk by the system.
REQ-005 key0..key3  input  1 each  raw asynchronous request lines (switch/button), key3 highest priority downstream.
REQ-006 y0..y3  output  1 each  debounced registered levels, wired directly to the priority encoder's y0..y3 inputs.
REQ-007 chg  output  1  single-cycle pulse: at least one of y0..y3 changed on this edge.
REQ-008 any  output  1  registered OR of y0..y3 (request present, encoder output a1/a0 meaningful).

Function
REQ-009 Each key_i SHALL pass through a two-flop synchronizer; second-stage output is s_i; no other logic SHALL use key_i.
REQ-010 Channels 0..3 SHALL be fully independent: own counter cnt_i, own y_i; no cross-channel priority inside this block.
REQ-011 At each edge, if s_i == y_i: cnt_i <= 0, y_i holds.
REQ-012 At each edge, if s_i != y_i and cnt_i < DB_CYCLES-1: cnt_i <= cnt_i+1, y_i holds.
REQ-013 At each edge, if s_i != y_i and cnt_i == DB_CYCLES-1: y_i <= s_i, cnt_i <= 0.
REQ-014 cnt_i SHALL never exceed DB_CYCLES-1 (no wrap).
REQ-015 Latency: key_i stable at new level from sampling edge E0 onward -> y_i updates at edge E0+DB_CYCLES+1 (E0+5 at default).
REQ-016 Any s_i return to y_i before acceptance SHALL clear cnt_i; glitches shorter than DB_CYCLES synchronized cycles SHALL never reach y_i.
REQ-017 Same rules apply to rising and falling transitions (press and release symmetric).
REQ-018 chg SHALL be asserted high for exactly the cycle following an edge on which any y_i updated (registered, same edge as y update); otherwise low.
REQ-019 Simultaneous updates on several channels in one edge SHALL produce one chg pulse, not one per channel.
REQ-020 Updates on consecutive edges (different channels) SHALL keep chg high for each such cycle.
REQ-021 any SHALL equal y0|y1|y2|y3 computed from next-state values so that any and y_i change on the same edge.
REQ-022 Outputs SHALL be glitch-free flop outputs; no combinational path from key_i to any output.

Reset
REQ-023 On rst_n low: synchronizer flops, cnt0..cnt3, y0..y3, chg, any SHALL all go to 0 immediately, independent of clk.
REQ-024 Reset asserted mid-debounce SHALL discard partial count; after release, a still-held key requires full DB_CYCLES+1 edges from first sampling edge.
REQ-025 Keys held high through reset release SHALL be treated as new transitions (y_i rises after REQ-015 latency, chg pulses).

Verification
REQ-026 DB_CYCLES=4, key2 0->1 held, sampled at edge 10 -> y2=1, any=1 at edge 15; chg=1 for cycle 15..16 only; y0,y1,y3 stay 0.
REQ-027 key1 high for 3 clk cycles then low -> y1, chg, any stay 0 throughout; cnt1 returns to 0.
REQ-028 key3 bouncing 1,0,1,0 each cycle then stable 1 -> y3 rises exactly DB_CYCLES+1 edges after the last 0->1 sampling edge; single chg pulse.
REQ-029 key0 and key3 rise in same cycle -> y0 and y3 update on same edge, one chg pulse; then key3 released -> y3 falls DB_CYCLES+1 edges later, chg pulses, any stays 1 (y0 held).
REQ-030 key1 held high, rst_n pulsed low for 1 cycle at count 2 -> all outputs 0 asynchronously; after release y1 rises at full latency from first post-reset sampling edge.
REQ-031 All four keys held 1 from reset release -> y0..y3=1 on same edge, any=1, single chg pulse; downstream encoder sees y3 set (a1=1, a0=1).
